// File: rtl/tt_uart_tx.sv
// UART transmitter, LSB first, CLK_DIV clocks per bit, valid/ready byte input; 8N1 by default.
// Defining TT_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module tt_uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

`ifdef TT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end;
`ifdef TT_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // rst_n gates ready so the port reads 0 while the block is held in reset.
  assign tx_ready = rst_n && ena && (state_q == IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign bit_end  = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef TT_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == IDLE) begin
      if (tx_valid && tx_ready) begin
        state_d = START;
        cnt_d   = '0;
        bit_d   = '0;
        shift_d = tx_data;
`ifdef TT_UART_TX_PARITY_EN
        par_d   = ^tx_data;
`endif
      end
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      if (bit_end) begin
        case (state_q)
          START: state_d = DATA;
          DATA: begin
            if (bit_q == 3'd7) begin
`ifdef TT_UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + 3'd1;
            end
          end
`ifdef TT_UART_TX_PARITY_EN
          PARITY:  state_d = STOP;
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from next state so tx/busy come straight from flops.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef TT_UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef TT_UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_tt_uart_tx.sv
// Bench for tt_uart_tx: frame-level reference model, per-cycle line checks and a UART receiver scoreboard.
module tb_tt_uart_tx;

  localparam int D = 4;
`ifdef TT_UART_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  tt_uart_tx #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a countdown of NB*D cycles over a fixed bit vector.
  int         frame_left = 0;
  logic [7:0] frame_dat  = '0;
  int         acc_n      = 0;
  logic [7:0] exp_q[$];
  int         cyc        = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (frame_left > 0 && exp_q.size() > 0) void'(exp_q.pop_back());
      frame_left = 0;
    end else if (frame_left > 0) begin
      frame_left--;
    end else if (tx_valid && ena) begin
      frame_left = NB * D;
      frame_dat  = tx_data;
      exp_q.push_back(tx_data);
      acc_n++;
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (frame_left == 0) return 1'b1;
    idx = (NB * D - frame_left) / D;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return frame_dat[idx-1];
    if (PAR && idx == 9) return ^frame_dat;
    return 1'b1;
  endfunction

  // Per-cycle comparison of every output against the model.
  bit b2b      = 1'b0;
  int last_acc = -1;

  always @(negedge clk) begin
    chk("tx_line",  32'(tx),       32'(exp_tx()));
    chk("busy",     32'(busy),     32'(frame_left > 0));
    chk("tx_ready", 32'(tx_ready), 32'(rst_n && ena && frame_left == 0));
    if (b2b && tx_valid && tx_ready) begin
      if (last_acc >= 0) chk("accept_spacing", 32'(cyc - last_acc), 32'(NB * D + 1));
      last_acc = cyc;
    end
  end

  // Receiver: samples mid-bit, decodes frames and pops the scoreboard.
  bit          rx_act = 1'b0;
  int          rx_t   = 0;
  logic [10:0] rx_bits;
  logic [7:0]  rx_exp;

  always @(negedge clk) begin
    if (!rst_n) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
    end else rx_t++;
    if (rx_act && (rx_t % D) == D / 2) begin
      rx_bits[rx_t / D] = tx;
      if (rx_t / D == NB - 1) begin
        rx_act = 1'b0;
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_frame", 32'(rx_bits[8:1]), 32'hFFFF_FFFF);
        end else begin
          rx_exp = exp_q.pop_front();
          chk("rx_start", 32'(rx_bits[0]),    32'd0);
          chk("rx_byte",  32'(rx_bits[8:1]),  32'(rx_exp));
          if (PAR) chk("rx_parity", 32'(rx_bits[9]), 32'(^rx_exp));
          chk("rx_stop",  32'(rx_bits[NB-1]), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && frame_left != 0; i++) step();
    chk("idle_reached", 32'(frame_left), 32'd0);
  endtask

  task automatic send_one(input logic [7:0] b);
    wait_idle();
    tx_valid = 1'b1;
    tx_data  = b;
    step();
    tx_valid = 1'b0;
    tx_data  = $urandom;
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 200 && acc_n < target; i++) step();
    chk("accept_reached", 32'(acc_n), 32'(target));
  endtask

  initial begin
    int bc;
    int rc;
    int n0;
    tx_valid = 1'b0;
    tx_data  = '0;
    ena      = 1'b1;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) step();
    chk("reset_tx",    32'(tx),       32'd1);
    chk("reset_busy",  32'(busy),     32'd0);
    chk("reset_ready", 32'(tx_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(tx_ready), 32'd1);
    repeat (20) step();

    // Single byte with busy/ready window measurement.
    send_one(8'hA5);
    bc = 0;
    rc = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy) bc++;
      if (!tx_ready) rc++;
      step();
    end
    chk("busy_len",      32'(bc), 32'(NB * D));
    chk("ready_low_len", 32'(rc), 32'(NB * D));

    // Back-to-back with tx_valid held high.
    wait_idle();
    n0 = acc_n;
    last_acc = -1;
    b2b = 1'b1;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    wait_acc(n0 + 1);
    tx_data = 8'hFF;
    wait_acc(n0 + 2);
    tx_data = 8'h00;
    wait_acc(n0 + 3);
    tx_valid = 1'b0;
    b2b = 1'b0;
    chk("b2b_spacing_seen", 32'(last_acc >= 0), 32'd1);

    // Enable gating.
    wait_idle();
    n0 = acc_n;
    ena = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55;
    repeat (100) step();
    chk("ena0_no_accept", 32'(acc_n - n0), 32'd0);
    ena = 1'b1;
    tx_data = 8'h3C;
    step();
    tx_data = 8'h99;
    repeat (10) step();
    ena = 1'b0;
    repeat (60) step();
    chk("ena_drop_one_accept", 32'(acc_n - n0), 32'd1);
    ena = 1'b1;
    wait_acc(n0 + 2);
    tx_valid = 1'b0;

    // Reset during data bit 3.
    send_one(8'h5A);
    repeat (4 * D) step();
    #3 rst_n = 1'b0;
    #1;
    chk("abort_tx",    32'(tx),       32'd1);
    chk("abort_busy",  32'(busy),     32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    send_one(8'h81);

    send_one(8'h07);
    send_one(8'h03);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ena      = ($urandom_range(0, 15) != 0);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = $urandom;
      step();
    end
    tx_valid = 1'b0;
    ena = 1'b1;
    wait_idle();
    repeat (10) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
